// File: rtl/spi_rx_frame_ctrl.sv
// SPI mode-0 slave frame receiver in the CLOCK_50 domain: synchronises the raw pins,
// checks frame length and timeout, commits good words and echoes the last one on MISO.
module spi_rx_frame_ctrl #(
    parameter int unsigned WORD_BITS      = 32,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic                 spi_sclk,
    input  logic                 spi_ss,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    output logic [WORD_BITS-1:0] disp_word,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic [7:0]           frame_count,
    output logic [7:0]           err_count,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(WORD_BITS + 2);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT,
        ST_REJECT
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

    logic [WORD_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [WORD_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 tmo_abort_q, tmo_abort_d;
    logic                 miso_q, miso_d;
    logic                 miso_oe_q, miso_oe_d;
    logic [WORD_BITS-1:0] disp_q, disp_d;
    logic                 fv_q, fv_d;
    logic                 fe_q, fe_d;
    logic [7:0]           fc_q, fc_d;
    logic [7:0]           ec_q, ec_d;
    logic                 busy_q, busy_d;

    // Pin synchronisers plus one extra stage for edge detection
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) state_q <= ST_WAIT_IDLE;
        else          state_q <= state_d;
    end

    // Next state and next values of every datapath/output register
    always_comb begin
        state_d     = state_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_d       = tmo_q;
        tmo_abort_d = tmo_abort_q;
        miso_d      = miso_q;
        disp_d      = disp_q;
        fv_d        = 1'b0;
        fe_d        = 1'b0;
        fc_d        = fc_q;
        ec_d        = ec_q;

        case (state_q)
            ST_WAIT_IDLE: begin
                if (ss_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = '0;
                    tmo_d      = '0;
                    tx_shift_d = disp_q;
                    miso_d     = disp_q[WORD_BITS-1];
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[WORD_BITS-2:0], mosi_s};
                    if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (sclk_fall) begin
                    tx_shift_d = {tx_shift_q[WORD_BITS-2:0], 1'b0};
                    miso_d     = tx_shift_q[WORD_BITS-2];
                end
                // Length is judged on the count including a bit taken this same cycle
                if (ss_rise) begin
                    tmo_abort_d = 1'b0;
                    state_d     = (bit_cnt_d == CNT_FULL) ? ST_COMMIT : ST_REJECT;
                end else if (!sclk_rise && (tmo_q == TMO_LAST)) begin
                    tmo_abort_d = 1'b1;
                    state_d     = ST_REJECT;
                end
            end
            ST_COMMIT: begin
                disp_d  = rx_shift_q;
                fv_d    = 1'b1;
                fc_d    = fc_q + 8'd1;
                state_d = ST_IDLE;
            end
            ST_REJECT: begin
                fe_d = 1'b1;
                if (ec_q != 8'hFF) ec_d = ec_q + 8'd1;
                state_d = tmo_abort_q ? ST_WAIT_IDLE : ST_IDLE;
            end
            default: state_d = ST_WAIT_IDLE;
        endcase

        miso_oe_d = (state_d == ST_SHIFT);
        busy_d    = (state_d == ST_SHIFT);
        if (state_d != ST_SHIFT) miso_d = 1'b0;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            tmo_abort_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            disp_q      <= '0;
            fv_q        <= 1'b0;
            fe_q        <= 1'b0;
            fc_q        <= '0;
            ec_q        <= '0;
            busy_q      <= 1'b0;
        end else begin
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_q       <= tmo_d;
            tmo_abort_q <= tmo_abort_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            disp_q      <= disp_d;
            fv_q        <= fv_d;
            fe_q        <= fe_d;
            fc_q        <= fc_d;
            ec_q        <= ec_d;
            busy_q      <= busy_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign disp_word   = disp_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign frame_count = fc_q;
    assign err_count   = ec_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_rx_frame_ctrl.sv
// Randomised bench for spi_rx_frame_ctrl: an SPI master task drives frames and a
// frame-level model (length rule, counters, echo word) supplies the expected values.
`timescale 1ns/1ps
module tb_spi_rx_frame_ctrl;

    localparam int unsigned WB   = 32;
    localparam int unsigned SYNC = 2;
    localparam int unsigned TMO  = 1000;

    logic        clk, rst_n, sclk, ss, mosi;
    logic        spi_miso, spi_miso_oe, frame_valid, frame_err, busy;
    logic [31:0] disp_word;
    logic [7:0]  frame_count, err_count;

    spi_rx_frame_ctrl #(.WORD_BITS(WB), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .spi_sclk(sclk), .spi_ss(ss), .spi_mosi(mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .disp_word(disp_word),
        .frame_valid(frame_valid), .frame_err(frame_err), .frame_count(frame_count),
        .err_count(err_count), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;

    // Reference model state
    logic [31:0] m_disp;
    int          m_fc, m_ec;

    logic [63:0] rx_bits;
    int          lat;
    logic        mid_busy, mid_oe;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (frame_err)   fe_cnt++;
    end

    function automatic void model_frame(input int nbits, input logic [63:0] data);
        if (nbits == 32) begin
            m_disp = data[31:0];
            m_fc   = (m_fc + 1) % 256;
        end else if (m_ec < 255) begin
            m_ec = m_ec + 1;
        end
    endfunction

    function automatic logic [63:0] exp_miso(input logic [31:0] w, input int nbits);
        logic [63:0] r = '0;
        for (int i = 0; i < nbits; i++) r = {r[62:0], (i < 32) ? w[31 - i] : 1'b0};
        return r;
    endfunction

    // Mode-0 master: data[nbits-1] first, MISO sampled just before each rising SCLK
    task automatic spi_xfer(input logic [63:0] data, input int nbits, input int hp);
        rx_bits = '0;
        @(negedge clk);
        ss = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = data[nbits - 1 - i];
            repeat (hp) @(negedge clk);
            rx_bits = {rx_bits[62:0], spi_miso};
            if (i == 0) begin
                mid_busy = busy;
                mid_oe   = spi_miso_oe;
            end
            sclk = 1'b1;
            repeat (hp) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (hp) @(negedge clk);
        ss  = 1'b1;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (lat < 0 && (frame_valid || frame_err)) lat = k;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_disp = '0;
        m_fc   = 0;
        m_ec   = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_miso, spi_miso_oe, disp_word, frame_valid, frame_err, frame_count, err_count, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got disp=%h fc=%0d ec=%0d busy=%b oe=%b exp all zero",
                     disp_word, frame_count, err_count, busy, spi_miso_oe);
        end
        rst_n = 1'b1;
        m_disp = '0;
        m_fc   = 0;
        m_ec   = 0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_basic();
        int f0 = fv_cnt, e0 = fe_cnt;
        logic [63:0] em = exp_miso(m_disp, 32);
        spi_xfer(64'hA5C30F81, 32, 5);
        model_frame(32, 64'hA5C30F81);
        checks++;
        if (disp_word !== 32'hA5C30F81) begin errors++; $display("FAIL basic_disp got %h exp a5c30f81", disp_word); end
        checks++;
        if (frame_count !== 8'(m_fc)) begin errors++; $display("FAIL basic_fc got %0d exp %0d", frame_count, m_fc); end
        checks++;
        if (fv_cnt - f0 != 1 || fe_cnt != e0) begin
            errors++; $display("FAIL basic_pulses got fv=%0d fe=%0d exp 1 0", fv_cnt - f0, fe_cnt - e0);
        end
        checks++;
        if (lat != int'(SYNC) + 2) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, SYNC + 2); end
        checks++;
        if (rx_bits !== em) begin errors++; $display("FAIL basic_miso got %h exp %h", rx_bits, em); end
        checks++;
        if (mid_busy !== 1'b1 || mid_oe !== 1'b1) begin
            errors++; $display("FAIL basic_shift_flags got busy=%b oe=%b exp 1 1", mid_busy, mid_oe);
        end
        checks++;
        if (busy !== 1'b0 || spi_miso_oe !== 1'b0) begin
            errors++; $display("FAIL basic_idle_flags got busy=%b oe=%b exp 0 0", busy, spi_miso_oe);
        end
    endtask

    task automatic test_echo();
        logic [63:0] em;
        spi_xfer(64'h12345678, 32, 5);
        model_frame(32, 64'h12345678);
        em = exp_miso(m_disp, 32);
        spi_xfer(64'h00000001, 32, 5);
        model_frame(32, 64'h00000001);
        checks++;
        if (rx_bits[31:0] !== 32'h12345678 || rx_bits !== em) begin
            errors++; $display("FAIL echo_miso got %h exp 12345678", rx_bits);
        end
        checks++;
        if (disp_word !== 32'h00000001) begin errors++; $display("FAIL echo_disp got %h exp 00000001", disp_word); end
    endtask

    task automatic test_length_err();
        int lens[2] = '{31, 33};
        for (int j = 0; j < 2; j++) begin
            int f0 = fv_cnt, e0 = fe_cnt;
            logic [63:0] d = {$urandom, $urandom};
            logic [63:0] em = exp_miso(m_disp, lens[j]);
            spi_xfer(d, lens[j], 5);
            model_frame(lens[j], d);
            checks++;
            if (fe_cnt - e0 != 1 || fv_cnt != f0) begin
                errors++; $display("FAIL len%0d_pulses got fe=%0d fv=%0d exp 1 0", lens[j], fe_cnt - e0, fv_cnt - f0);
            end
            checks++;
            if (disp_word !== m_disp || frame_count !== 8'(m_fc)) begin
                errors++; $display("FAIL len%0d_hold got disp=%h fc=%0d exp %h %0d", lens[j], disp_word, frame_count, m_disp, m_fc);
            end
            checks++;
            if (rx_bits !== em) begin errors++; $display("FAIL len%0d_miso got %h exp %h", lens[j], rx_bits, em); end
        end
        checks++;
        if (err_count !== 8'(m_ec) || m_ec != 2) begin
            errors++; $display("FAIL len_err_count got %0d exp 2", err_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int f0 = fv_cnt, e0 = fe_cnt, nb;
            int r = int'($urandom_range(0, 3));
            logic [63:0] d = {$urandom, $urandom};
            logic [63:0] em;
            nb = (r == 0) ? int'($urandom_range(1, 31)) : (r == 3) ? int'($urandom_range(33, 40)) : 32;
            em = exp_miso(m_disp, nb);
            spi_xfer(d, nb, int'($urandom_range(4, 6)));
            model_frame(nb, d);
            checks++;
            if (disp_word !== m_disp || frame_count !== 8'(m_fc) || err_count !== 8'(m_ec)) begin
                errors++;
                $display("FAIL rand%0d_state nb=%0d got disp=%h fc=%0d ec=%0d exp %h %0d %0d",
                         n, nb, disp_word, frame_count, err_count, m_disp, m_fc, m_ec);
            end
            checks++;
            if (fv_cnt - f0 != ((nb == 32) ? 1 : 0) || fe_cnt - e0 != ((nb == 32) ? 0 : 1)) begin
                errors++; $display("FAIL rand%0d_pulses nb=%0d got fv=%0d fe=%0d", n, nb, fv_cnt - f0, fe_cnt - e0);
            end
            checks++;
            if (rx_bits !== em) begin errors++; $display("FAIL rand%0d_miso got %h exp %h", n, rx_bits, em); end
        end
    endtask

    task automatic test_timeout();
        int f0 = fv_cnt, e0 = fe_cnt, t = -1;
        logic [63:0] d;
        @(negedge clk);
        ss = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom);
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            if (i < 9) begin
                repeat (5) @(negedge clk);
                sclk = 1'b0;
            end
        end
        // Count cycles from the last raw SCLK rise to the error pulse
        for (int k = 1; k <= int'(TMO) + 200 && t < 0; k++) begin
            @(negedge clk);
            if (k == 5) sclk = 1'b0;
            if (frame_err) t = k;
        end
        if (m_ec < 255) m_ec++;
        checks++;
        if (t < int'(TMO) || t > int'(TMO + SYNC) + 4) begin
            errors++; $display("FAIL timeout_delay got %0d exp %0d..%0d", t, TMO, TMO + SYNC + 4);
        end
        checks++;
        if (err_count !== 8'(m_ec) || fv_cnt != f0) begin
            errors++; $display("FAIL timeout_count got ec=%0d fv=%0d exp %0d 0", err_count, fv_cnt - f0, m_ec);
        end
        // SS still low: a full word of clocks must be ignored
        for (int i = 0; i < 32; i++) begin
            mosi = 1'($urandom);
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        ss = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (fe_cnt - e0 != 1 || fv_cnt != f0 || disp_word !== m_disp) begin
            errors++; $display("FAIL timeout_wait_idle got fe=%0d fv=%0d disp=%h exp 1 0 %h", fe_cnt - e0, fv_cnt - f0, disp_word, m_disp);
        end
        d = {32'h0, $urandom};
        spi_xfer(d, 32, 5);
        model_frame(32, d);
        checks++;
        if (disp_word !== m_disp || fv_cnt - f0 != 1 || frame_count !== 8'(m_fc)) begin
            errors++; $display("FAIL timeout_recover got disp=%h fc=%0d exp %h %0d", disp_word, frame_count, m_disp, m_fc);
        end
    endtask

    task automatic test_reset_midframe();
        int f0, e0;
        logic [63:0] d;
        @(negedge clk);
        ss = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mosi = 1'($urandom);
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
            if (i == 15) begin
                rst_n = 1'b0;
                #1;
                m_disp = '0;
                m_fc   = 0;
                m_ec   = 0;
                checks++;
                if ({disp_word, frame_count, err_count, busy, spi_miso_oe} !== '0) begin
                    errors++; $display("FAIL midreset_outputs got disp=%h fc=%0d ec=%0d busy=%b exp zero", disp_word, frame_count, err_count, busy);
                end
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                f0 = fv_cnt;
                e0 = fe_cnt;
            end
        end
        repeat (5) @(negedge clk);
        ss = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (fv_cnt != f0 || fe_cnt != e0 || disp_word !== 32'h0) begin
            errors++; $display("FAIL midreset_discard got fv=%0d fe=%0d disp=%h exp 0 0 0", fv_cnt - f0, fe_cnt - e0, disp_word);
        end
        d = {32'h0, $urandom};
        spi_xfer(d, 32, 5);
        model_frame(32, d);
        checks++;
        if (disp_word !== m_disp || frame_count !== 8'd1 || rx_bits !== 64'h0) begin
            errors++; $display("FAIL midreset_next got disp=%h fc=%0d miso=%h exp %h 1 0", disp_word, frame_count, rx_bits, m_disp);
        end
    endtask

    task automatic test_wrap_saturate();
        int f0, e0;
        do_reset();
        f0 = fv_cnt;
        for (int i = 0; i < 256; i++) begin
            logic [63:0] d = {32'h0, $urandom};
            spi_xfer(d, 32, 4);
            model_frame(32, d);
            if (i == 254) begin
                checks++;
                if (frame_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d exp 255", frame_count); end
            end
        end
        checks++;
        if (frame_count !== 8'd0 || m_fc != 0 || fv_cnt - f0 != 256 || disp_word !== m_disp) begin
            errors++; $display("FAIL wrap_zero got fc=%0d pulses=%0d disp=%h exp 0 256 %h", frame_count, fv_cnt - f0, disp_word, m_disp);
        end
        e0 = fe_cnt;
        for (int i = 0; i < 300; i++) begin
            int nb = int'($urandom_range(0, 3));
            logic [63:0] d = {32'h0, $urandom};
            spi_xfer(d, nb, 4);
            model_frame(nb, d);
        end
        checks++;
        if (err_count !== 8'd255 || m_ec != 255 || fe_cnt - e0 != 300) begin
            errors++; $display("FAIL saturate got ec=%0d pulses=%0d exp 255 300", err_count, fe_cnt - e0);
        end
        checks++;
        if (frame_count !== 8'(m_fc) || disp_word !== m_disp) begin
            errors++; $display("FAIL saturate_hold got fc=%0d disp=%h exp %0d %h", frame_count, disp_word, m_fc, m_disp);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sclk  = 1'b0;
        ss    = 1'b1;
        mosi  = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_echo();
        test_length_err();
        test_random();
        test_timeout();
        test_reset_midframe();
        test_wrap_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
